// File: rtl/top_pkg.sv
// Shared constants and types for the packed-BCD adder.
package top_pkg;
  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX        = 9;
  localparam int unsigned BCD_CORRECTION = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal carry; optional non-BCD operand flag
// when TOP_INVALID_DETECT_EN is defined.
module bcd_digit_adder
  import top_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
`ifdef TOP_INVALID_DETECT_EN
  output logic       bad,
`endif
  output bcd_digit_t s,
  output logic       co
);
  localparam int unsigned SUM_W = BCD_DIGIT_W + 1;

  logic [SUM_W-1:0] w_sum;

  // Binary sum ranges 0..31; anything above 9 is corrected by +6 mod 16.
  assign w_sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(ci);
  assign co    = (w_sum > SUM_W'(BCD_MAX));
  assign s     = co ? (w_sum[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORRECTION))
                    : w_sum[BCD_DIGIT_W-1:0];

`ifdef TOP_INVALID_DETECT_EN
  assign bad = (a > BCD_DIGIT_W'(BCD_MAX)) || (b > BCD_DIGIT_W'(BCD_MAX));
`endif
endmodule

// File: rtl/top.sv
// Registered multi-digit packed-BCD adder built as a ripple of digit adders.
// Optional feature macro: TOP_INVALID_DETECT_EN adds the registered invalid flag.
module top
  import top_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] inputA,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] inputB,
  input  logic                        cin,
`ifdef TOP_INVALID_DETECT_EN
  output logic                        invalid,
`endif
  output logic [BCD_DIGIT_W*DIGITS-1:0] result,
  output logic                        cout
);
  localparam int unsigned W = BCD_DIGIT_W * DIGITS;

  logic [DIGITS:0] w_carry;
  logic [W-1:0]    w_sum;
  logic [W-1:0]    r_result;
  logic            r_cout;
`ifdef TOP_INVALID_DETECT_EN
  logic [DIGITS-1:0] w_bad;
  logic              r_invalid;
`endif

  assign w_carry[0] = cin;

  // Carry chain: digit i consumes carry i and produces carry i+1.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_adder u_digit (
      .a  (inputA[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .b  (inputB[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ci (w_carry[i]),
`ifdef TOP_INVALID_DETECT_EN
      .bad(w_bad[i]),
`endif
      .s  (w_sum[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co (w_carry[i+1])
    );
  end

  // Single output stage; reset discards the operands of that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef TOP_INVALID_DETECT_EN
      r_invalid <= 1'b0;
`endif
    end else begin
      r_result <= w_sum;
      r_cout   <= w_carry[DIGITS];
`ifdef TOP_INVALID_DETECT_EN
      r_invalid <= |w_bad;
`endif
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
`ifdef TOP_INVALID_DETECT_EN
  assign invalid = r_invalid;
`endif
endmodule

// File: tb/tb_top.sv
// Self-checking bench for the registered 3-digit BCD adder.
module tb_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] inputA, inputB;
  logic        cin;
  logic [11:0] result;
  logic        cout;
`ifdef TOP_INVALID_DETECT_EN
  logic        invalid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        ci;
    logic [11:0] exp_res;
    logic        exp_cout;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[12];

  top #(.DIGITS(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .inputA (inputA),
    .inputB (inputB),
    .cin    (cin),
`ifdef TOP_INVALID_DETECT_EN
    .invalid(invalid),
`endif
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [11:0] er, input logic ec, input logic ei);
    check({name, ".result"}, 32'(result), 32'(er));
    check({name, ".cout"}, 32'(cout), 32'(ec));
`ifdef TOP_INVALID_DETECT_EN
    check({name, ".invalid"}, 32'(invalid), 32'(ei));
`else
    if (ei === 1'bx) $display("unexpected x in expected invalid for %s", name);
`endif
  endtask

  task automatic drive(input logic r, input logic [11:0] a, input logic [11:0] b, input logic c);
    rst = r; inputA = a; inputB = b; cin = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{12'h346, 12'h159, 1'b0, 12'h505, 1'b0, 1'b0};
    vecs[1]  = '{12'h505, 12'h519, 1'b0, 12'h024, 1'b1, 1'b0};
    vecs[2]  = '{12'h999, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[3]  = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[4]  = '{12'h999, 12'h999, 1'b1, 12'h999, 1'b1, 1'b0};
    vecs[5]  = '{12'h123, 12'h456, 1'b1, 12'h580, 1'b0, 1'b0};
    vecs[6]  = '{12'h00A, 12'h000, 1'b0, 12'h010, 1'b0, 1'b1};
    vecs[7]  = '{12'h050, 12'h050, 1'b0, 12'h100, 1'b0, 1'b0};
    vecs[8]  = '{12'h0F0, 12'h000, 1'b0, 12'h150, 1'b0, 1'b1};
    vecs[9]  = '{12'hFFF, 12'hFFF, 1'b1, 12'h555, 1'b1, 1'b1};
    vecs[10] = '{12'h000, 12'h009, 1'b1, 12'h010, 1'b0, 1'b0};
    vecs[11] = '{12'h499, 12'h500, 1'b0, 12'h999, 1'b0, 1'b0};

    // Reset held two edges with live operands
    drive(1'b1, 12'h999, 12'h999, 1'b1);
    step();
    check_out("reset_edge1", 12'h000, 1'b0, 1'b0);
    step();
    check_out("reset_edge2", 12'h000, 1'b0, 1'b0);

    // Table: each vector is sampled on one edge and checked just after it
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].ci);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_inv);
    end

    // Back-to-back operands then a mid-stream reset
    drive(1'b0, 12'h346, 12'h159, 1'b0);
    step();
    check_out("b2b_first", 12'h505, 1'b0, 1'b0);
    drive(1'b0, 12'h505, 12'h519, 1'b0);
    step();
    check_out("b2b_second", 12'h024, 1'b1, 1'b0);
    drive(1'b1, 12'hFFF, 12'h999, 1'b1);
    step();
    check_out("mid_reset", 12'h000, 1'b0, 1'b0);

    // Operands presented after reset release produce a result one edge later
    drive(1'b0, 12'h00A, 12'h000, 1'b0);
    step();
    check_out("post_reset_invalid", 12'h010, 1'b0, 1'b1);
    drive(1'b0, 12'h001, 12'h002, 1'b0);
    step();
    check_out("post_reset_valid", 12'h003, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
